// File: rtl/scroll_name_display.sv
// Multiplexed 7-segment scan driver: walks the anodes at a prescaled rate and
// shows a DIGITS-wide window, optionally scrolling, over a MSG_LEN-character buffer.
module scroll_name_display #(
  parameter int DIGITS     = 8,
  parameter int MSG_LEN    = 16,
  parameter int PRESCALE   = 50000,
  parameter int SCROLL_DIV = 512
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       msg_we,
  input  logic [$clog2(MSG_LEN)-1:0] msg_addr,
  input  logic [4:0]                 msg_char,
  input  logic                       scroll_en,
  input  logic                       blank,
  input  logic [DIGITS-1:0]          dp_mask,
  output logic [DIGITS-1:0]          an,
  output logic [6:0]                 seg,
  output logic                       dp
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(PRESCALE);
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(SCROLL_DIV - 1);
  localparam logic [DW-1:0] D_LAST    = DW'(DIGITS - 1);

  logic [PW-1:0]     pcnt_r, pcnt_nxt_s;
  logic [DW-1:0]     d_r, d_nxt_s;
  logic [SW-1:0]     scnt_r, scnt_nxt_s;
  logic [AW-1:0]     scroll_pos_r, scroll_pos_nxt_s;
  logic [4:0]        msg_buf_r [MSG_LEN];
  logic              tick_s, step_s;
  logic [AW-1:0]     rd_addr_s;
  logic [4:0]        char_s;
  logic [DIGITS-1:0] one_hot_s;

  // Active-low gfedcba pattern for each character code; unknown codes are dark.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'h00: g = 7'h40;
      5'h01: g = 7'h79;
      5'h02: g = 7'h24;
      5'h03: g = 7'h30;
      5'h04: g = 7'h19;
      5'h05: g = 7'h12;
      5'h06: g = 7'h02;
      5'h07: g = 7'h78;
      5'h08: g = 7'h00;
      5'h09: g = 7'h10;
      5'h0A: g = 7'h08;
      5'h0B: g = 7'h03;
      5'h0C: g = 7'h46;
      5'h0D: g = 7'h21;
      5'h0E: g = 7'h06;
      5'h0F: g = 7'h0E;
      5'h10: g = 7'h09;
      5'h11: g = 7'h47;
      5'h12: g = 7'h2B;
      5'h13: g = 7'h23;
      5'h14: g = 7'h0C;
      5'h15: g = 7'h2F;
      5'h16: g = 7'h41;
      5'h17: g = 7'h11;
      5'h18: g = 7'h3F;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Next-state logic for prescaler, digit walker and scroll position.
  always_comb begin
    tick_s = (pcnt_r == PCNT_LAST);
    step_s = tick_s && scroll_en && (scnt_r == SCNT_LAST);

    if (tick_s) begin
      pcnt_nxt_s = {PW{1'b0}};
    end else begin
      pcnt_nxt_s = pcnt_r + PW'(1'b1);
    end

    if (!tick_s) begin
      d_nxt_s = d_r;
    end else if (d_r == D_LAST) begin
      d_nxt_s = {DW{1'b0}};
    end else begin
      d_nxt_s = d_r + DW'(1'b1);
    end

    // Holding scnt at zero while disabled makes the first step a full period away.
    if (!scroll_en) begin
      scnt_nxt_s = {SW{1'b0}};
    end else if (!tick_s) begin
      scnt_nxt_s = scnt_r;
    end else if (scnt_r == SCNT_LAST) begin
      scnt_nxt_s = {SW{1'b0}};
    end else begin
      scnt_nxt_s = scnt_r + SW'(1'b1);
    end

    if (step_s) begin
      scroll_pos_nxt_s = scroll_pos_r + AW'(1'b1);
    end else begin
      scroll_pos_nxt_s = scroll_pos_r;
    end
  end

  // Window read: the address wraps by truncation at MSG_LEN.
  always_comb begin
    rd_addr_s = scroll_pos_r + AW'(d_r);
    char_s    = msg_buf_r[rd_addr_s];
    one_hot_s = {{(DIGITS-1){1'b0}}, 1'b1} << d_r;
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_r       <= {PW{1'b0}};
      d_r          <= {DW{1'b0}};
      scnt_r       <= {SW{1'b0}};
      scroll_pos_r <= {AW{1'b0}};
    end else begin
      pcnt_r       <= pcnt_nxt_s;
      d_r          <= d_nxt_s;
      scnt_r       <= scnt_nxt_s;
      scroll_pos_r <= scroll_pos_nxt_s;
    end
  end

  // Message buffer; reset fills it with the blank code.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_buf_r[i] <= 5'h1F;
      end
    end else if (msg_we) begin
      msg_buf_r[msg_addr] <= msg_char;
    end
  end

  // Registered display drive; an, seg and dp always change together.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= {DIGITS{1'b1}};
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      seg <= glyph(char_s);
      if (blank) begin
        an <= {DIGITS{1'b1}};
        dp <= 1'b1;
      end else begin
        an <= ~one_hot_s;
        dp <= ~dp_mask[d_r];
      end
    end
  end

endmodule

// File: tb/tb_scroll_name_display.sv
// Directed bench for scroll_name_display with DIGITS=4, MSG_LEN=8, PRESCALE=4, SCROLL_DIV=2.
module tb_scroll_name_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       msg_we;
  logic [2:0] msg_addr;
  logic [4:0] msg_char;
  logic       scroll_en;
  logic       blank;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int cyc;
  int errors = 0;
  int checks = 0;

  logic [3:0] an_tab [4];
  logic [6:0] g07 [8];
  logic [6:0] g5 [4];

  scroll_name_display #(
    .DIGITS(4), .MSG_LEN(8), .PRESCALE(4), .SCROLL_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .msg_we(msg_we), .msg_addr(msg_addr),
    .msg_char(msg_char), .scroll_en(scroll_en), .blank(blank),
    .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [3:0] ean, input logic [6:0] eseg, input logic edp);
    checks++;
    assert ({an, seg, dp} === {ean, eseg, edp}) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b",
             tag, cyc, an, seg, dp, ean, eseg, edp);
    end
  endtask

  // Digit index visible after post-reset edge n (digit held 4 edges).
  function automatic int dig(input int n);
    return ((n - 1) / 4) % 4;
  endfunction

  initial begin
    int k;
    int sp;
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    g07    = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    g5     = '{7'h3F, 7'h7F, 7'h00, 7'h7F};
    reset = 1'b1; msg_we = 1'b0; msg_addr = 3'd0; msg_char = 5'd0;
    scroll_en = 1'b0; blank = 1'b0; dp_mask = 4'b0000; cyc = 0;

    // Reset and first edge after release
    repeat (3) begin
      step();
      chk("reset", 4'b1111, 7'h7F, 1'b1);
    end
    reset = 1'b0; cyc = 0;
    msg_we = 1'b1; msg_addr = 3'd0; msg_char = 5'h00;
    step();
    chk("first_edge", 4'b1110, 7'h7F, 1'b1);
    msg_addr = 3'd1; msg_char = 5'h01;
    step();
    chk("write_visible", 4'b1110, 7'h40, 1'b1);
    msg_addr = 3'd2; msg_char = 5'h02;
    step();
    msg_addr = 3'd3; msg_char = 5'h03;
    step();
    msg_we = 1'b0;

    // Static scan over digits 0..3, one full period
    for (int n = 5; n <= 20; n++) begin
      step();
      k = dig(cyc);
      chk("scan", an_tab[k], g07[k], 1'b1);
    end

    // Fill the rest of the buffer, then scroll
    for (int i = 4; i < 8; i++) begin
      msg_we = 1'b1; msg_addr = 3'(i); msg_char = 5'(i);
      step();
    end
    msg_we = 1'b0;
    scroll_en = 1'b1;
    for (int n = 25; n <= 100; n++) begin
      step();
      k  = dig(cyc);
      sp = (cyc <= 32) ? 0 : (((cyc - 33) / 8 + 1) % 8);
      chk("scroll", an_tab[k], g07[(sp + k) % 8], 1'b1);
      if (cyc == 33) chk("first_step", 4'b1110, 7'h79, 1'b1);
      if (cyc == 77) chk("wrap_sp6_d3", 4'b0111, 7'h79, 1'b1);
      if (cyc == 85) chk("wrap_sp7_d1", 4'b1101, 7'h40, 1'b1);
      if (cyc == 89) chk("sp_back_to_0", 4'b1011, 7'h24, 1'b1);
    end

    // Glyph, blanking and decimal point
    scroll_en = 1'b0; reset = 1'b1;
    step();
    chk("reset2", 4'b1111, 7'h7F, 1'b1);
    step();
    reset = 1'b0; cyc = 0;
    msg_we = 1'b1; msg_addr = 3'd0; msg_char = 5'h18;
    step();
    msg_addr = 3'd1; msg_char = 5'h19;
    step();
    msg_addr = 3'd2; msg_char = 5'h08;
    step();
    msg_we = 1'b0;
    chk("glyph_dash", 4'b1110, 7'h3F, 1'b1);
    repeat (2) step();
    chk("glyph_19", 4'b1101, 7'h7F, 1'b1);
    repeat (3) step();
    blank = 1'b1;
    step();
    chk("blank_on", 4'b1111, 7'h00, 1'b1);
    repeat (4) step();
    chk("blank_d3", 4'b1111, 7'h7F, 1'b1);
    blank = 1'b0;
    step();
    chk("unblank", 4'b0111, 7'h7F, 1'b1);
    dp_mask = 4'b0100;
    for (int n = 15; n <= 30; n++) begin
      step();
      k = dig(cyc);
      chk("dp_mask", an_tab[k], g5[k], (k == 2) ? 1'b0 : 1'b1);
    end

    // Reset in the middle of scrolling
    dp_mask = 4'b0000; scroll_en = 1'b1;
    msg_we = 1'b1; msg_addr = 3'd6; msg_char = 5'h0A;
    step();
    msg_we = 1'b0;
    while (cyc < 69) step();
    chk("sp5_d1", 4'b1101, 7'h08, 1'b1);
    step();
    reset = 1'b1;
    step();
    chk("reset_mid_scroll", 4'b1111, 7'h7F, 1'b1);
    step();
    reset = 1'b0; scroll_en = 1'b0; cyc = 0;
    for (int n = 1; n <= 16; n++) begin
      step();
      chk("post_reset_blank", an_tab[dig(cyc)], 7'h7F, 1'b1);
    end
    msg_we = 1'b1; msg_addr = 3'd0; msg_char = 5'h05;
    step();
    chk("write_same_edge", 4'b1110, 7'h7F, 1'b1);
    msg_we = 1'b0;
    step();
    chk("write_next_edge", 4'b1110, 7'h12, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scroll_name_display.md
Name: scroll_name_display

Overview:
Multi-digit 7-segment scan driver that consumes a character message and drives the multiplexed anode/segment lines of the board display. An internal prescaler paces digit scanning. A digit-select counter walks the anodes. An optional scroll counter rotates a window of DIGITS characters through a MSG_LEN-entry message buffer. Characters are written into the buffer by upstream logic.

Parameters:
DIGITS, 8, number of physical digits (anode width); power of 2, DIGITS <= MSG_LEN
MSG_LEN, 16, message buffer depth in characters; power of 2
PRESCALE, 50000, clk cycles per scan tick (>= 2)
SCROLL_DIV, 512, scan ticks per scroll step (>= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
msg_we  input  1  write strobe for message buffer
msg_addr  input  $clog2(MSG_LEN)  buffer write address
msg_char  input  5  character code to write
scroll_en  input  1  1 = advance scroll position every SCROLL_DIV ticks
blank  input  1  1 = all anodes off
dp_mask  input  DIGITS  1 = light decimal point on physical digit k
an  output  DIGITS  anode drive, active-low, one-hot-low while scanning
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low

Behaviour:
- Prescaler pcnt counts 0..PRESCALE-1 and wraps. tick = 1 in the cycle pcnt == PRESCALE-1.
- Digit index d (clog2(DIGITS) bits) increments on tick and wraps DIGITS-1 -> 0.
- Scroll counter scnt counts ticks 0..SCROLL_DIV-1.
  - On tick with scnt == SCROLL_DIV-1: scnt -> 0 and scroll_pos increments mod MSG_LEN (truncation wrap).
  - scroll_en = 0: scnt is held at 0 and scroll_pos holds. After scroll_en rises, the first step occurs after SCROLL_DIV full ticks.
- Physical digit k = d shows buffer[(scroll_pos + d) mod MSG_LEN]. an[0] is the leftmost digit.
- Outputs are registered with 1-cycle latency from d, scroll_pos and buffer contents:
  - an = ~(1 << d)
  - seg = glyph(char)
  - dp = ~dp_mask[d]
  - an, seg and dp update on the same edge, so they are never incoherent.
- blank = 1: an = all ones and dp = 1 on the next edge. seg still decodes. Counters keep running.
- Message buffer: MSG_LEN x 5 flops, written synchronously when msg_we = 1. A written value is visible to the decode one cycle later. A write to the address being displayed changes seg on the following edge.
- Glyph table (5-bit code -> seg, active-low gfedcba):
  - 00-09 digits 0-9: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - 0A A=08, 0B b=03, 0C C=46, 0D d=21, 0E E=06, 0F F=0E
  - 10 H=09, 11 L=47, 12 n=2B, 13 o=23, 14 P=0C, 15 r=2F, 16 U=41, 17 y=11
  - 18 '-'=3F
  - 19-1F and all others: blank = 7F
- Reset, at any time including mid-scan or mid-scroll, takes effect on the next edge:
  - pcnt, d, scnt, scroll_pos = 0
  - every buffer entry = 1F (blank)
  - an = all ones, seg = 7F, dp = 1
- First clock after reset deasserts: an = ~1, showing buffer[0].
- Simultaneous tick and scroll step: d and scroll_pos both update on the same edge. The next output uses both new values.

Test Plan:
All scenarios use sim params DIGITS=4, MSG_LEN=8, PRESCALE=4, SCROLL_DIV=2.
1. Reset held 3 cycles -> an=1111, seg=7F, dp=1. After release, the first edge gives an=1110, seg=7F (blank buffer).
2. Write buffer[0..3] = 00,01,02,03, scroll_en=0. Expected cycle, each digit held 4 cycles, period 16 cycles:
   - an=1110 / seg=40
   - an=1101 / seg=79
   - an=1011 / seg=24
   - an=0111 / seg=30
3. buffer[0..7] = 00..07, scroll_en=1. Every 8 cycles scroll_pos increments and an[0] shows buffer[scroll_pos]: seg=79 after the first step. After 8 steps scroll_pos returns to 0.
4. Wrap read: when scroll_pos=6 and d=3, the digit shows buffer[1] (seg=79). When scroll_pos=7 and d=1, it shows buffer[0] (seg=40).
5. Glyph and blanking checks:
   - code 18 -> seg=3F; code 19 -> seg=7F
   - blank=1 mid-scan -> an=1111 next edge while d continues advancing
   - dp_mask=0100 -> dp=0 only while an=1011
6. Reset asserted mid-scroll with scroll_pos=5 -> next edge gives an=1111, seg=7F. After release, scroll_pos=0 and all digits show 7F until rewritten.
